// File: rtl/bcd_pkg.sv
//==============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD digit constants and the load-value clamp helper used by
//            the BCD down-counter and its per-digit combinational cell.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Out-of-range nibbles (A..F) saturate to the largest legal BCD digit.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_down_combin.sv
//==============================================================================
// Module   : bcd_digit_down_combin
// Brief    : One-digit combinational BCD decrement cell. A borrow into a zero
//            digit produces 9 and passes the borrow upward.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_digit_down_combin
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    input  logic             bin,
    output logic [BCD_W-1:0] next_d,
    output logic             bout
);

    // Decrement the digit when borrowed from, wrapping 0 -> 9.
    always_comb begin
        next_d = d;
        bout   = bin & (d == BCD_ZERO);
        if (bin) begin
            next_d = (d == BCD_ZERO) ? BCD_MAX : (d - 4'd1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_down_counter.sv
//==============================================================================
// Module   : bcd_down_counter
// Brief    : Cascadable multi-digit BCD down-counter with parallel load,
//            combinational borrow-out / zero flags and registered done and
//            load-error pulses.
// Options  : BCD_DOWN_SATURATE_EN - when defined, the count holds at zero
//            instead of wrapping to all nines.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    ena,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     din,
    output logic [4*DIGITS-1:0]     q,
    output logic                    b_o,
    output logic                    zero,
    output logic                    done,
    output logic                    ld_err
);

    localparam int                 c_cnt_w = BCD_W * DIGITS;
    localparam logic [c_cnt_w-1:0] c_one   = {{(c_cnt_w-1){1'b0}}, 1'b1};

    logic [c_cnt_w-1:0] r_q;
    logic               r_done;
    logic               r_ld_err;

    logic [c_cnt_w-1:0] w_dec_q;
    logic [c_cnt_w-1:0] w_next_q;
    logic [c_cnt_w-1:0] w_load_q;
    logic [DIGITS:0]    w_borrow;
    logic [DIGITS-1:0]  w_digit_bad;
    logic               w_zero;
    logic               w_any_bad;

    // Borrow enters at the least significant digit and ripples upward.
    assign w_borrow[0] = ena;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit_down_combin u_cell (
                .d      (r_q[k*BCD_W +: BCD_W]),
                .bin    (w_borrow[k]),
                .next_d (w_dec_q[k*BCD_W +: BCD_W]),
                .bout   (w_borrow[k+1])
            );

            assign w_load_q[k*BCD_W +: BCD_W] = bcd_clamp(din[k*BCD_W +: BCD_W]);
            assign w_digit_bad[k]             = (din[k*BCD_W +: BCD_W] > BCD_MAX);
        end
    endgenerate

    assign w_zero    = (r_q == '0);
    assign w_any_bad = |w_digit_bad;

`ifdef BCD_DOWN_SATURATE_EN
    // At all-zero the decrement is suppressed; the borrow-out still fires.
    assign w_next_q = w_zero ? r_q : w_dec_q;
`else
    // The ripple chain wraps all-zero to all-nines on its own.
    assign w_next_q = w_dec_q;
`endif

    // Count register and status pulses: clear > load > decrement > hold.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q      <= '0;
            r_done   <= 1'b0;
            r_ld_err <= 1'b0;
        end else if (load) begin
            r_q      <= w_load_q;
            r_done   <= 1'b0;
            r_ld_err <= w_any_bad;
        end else if (ena) begin
            r_q      <= w_next_q;
            r_done   <= (r_q == c_one);
            r_ld_err <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_ld_err <= 1'b0;
        end
    end

    assign q      = r_q;
    assign zero   = w_zero;
    // Top of the borrow chain equals ena & (q == 0), ready for cascading.
    assign b_o    = w_borrow[DIGITS];
    assign done   = r_done;
    assign ld_err = r_ld_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
//==============================================================================
// Module   : tb_bcd_down_counter
// Brief    : Self-checking bench for bcd_down_counter (DIGITS = 4) using an
//            integer-valued reference model of the count.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_down_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         ena;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic         b_o;
    logic         zero;
    logic         done;
    logic         ld_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count as a plain decimal integer.
    int m_val  = 0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .ena    (ena),
        .load   (load),
        .din    (din),
        .q      (q),
        .b_o    (b_o),
        .zero   (zero),
        .done   (done),
        .ld_err (ld_err)
    );

    function automatic int din_value(input logic [W-1:0] d);
        int v = 0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            int dg;
            dg = int'(d[k*4 +: 4]);
            if (dg > 9) dg = 9;
            v = v * 10 + dg;
        end
        return v;
    endfunction

    function automatic bit din_bad(input logic [W-1:0] d);
        bit b = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(d[k*4 +: 4]) > 9) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic set_in(input logic c, input logic l, input logic e, input logic [W-1:0] d);
        clr_n = c;
        load  = l;
        ena   = e;
        din   = d;
    endtask

    // Advance one clock edge and update the model from the applied inputs.
    task automatic tick();
        @(posedge clk);
        if (!clr_n) begin
            m_val  = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (load) begin
            m_val  = din_value(din);
            m_done = 1'b0;
            m_err  = din_bad(din);
        end else if (ena) begin
            m_done = (m_val == 1);
            m_err  = 1'b0;
`ifdef BCD_DOWN_SATURATE_EN
            m_val  = (m_val == 0) ? 0 : m_val - 1;
`else
            m_val  = (m_val == 0) ? MAXV : m_val - 1;
`endif
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        n_checks++;
        if (q !== 16'h0000) $display("FAIL reset_q: got %h want 0000", q);
        else n_pass++;
        n_checks++;
        if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || ld_err !== 1'b0)
            $display("FAIL reset_flags: got done=%b ld_err=%b want 0 0", done, ld_err);
        else n_pass++;
        n_checks++;
        if (b_o !== 1'b1) $display("FAIL reset_bo: got %b want 1", b_o);
        else n_pass++;
        set_in(1'b1, 1'b0, 1'b0, '0);
        #1;
        n_checks++;
        if (b_o !== 1'b0) $display("FAIL reset_bo_idle: got %b want 0", b_o);
        else n_pass++;
    endtask

    task automatic test_ripple();
        set_in(1'b1, 1'b1, 1'b0, 16'h1000);
        tick();
        set_in(1'b1, 1'b0, 1'b1, '0);
        tick();
        n_checks++;
        if (q !== 16'h0999) $display("FAIL ripple_q: got %h want 0999", q);
        else n_pass++;
    endtask

    task automatic test_countdown();
        set_in(1'b1, 1'b1, 1'b0, 16'h0003);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b1, '0);
            tick();
            n_checks++;
            if (q !== 16'(2 - i)) $display("FAIL countdown_q%0d: got %h want %h", i, q, 16'(2 - i));
            else n_pass++;
            n_checks++;
            if (done !== (i == 2)) $display("FAIL countdown_done%0d: got %b want %b", i, done, (i == 2));
            else n_pass++;
        end
        n_checks++;
        if (zero !== 1'b1) $display("FAIL countdown_zero: got %b want 1", zero);
        else n_pass++;
        set_in(1'b1, 1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if (done !== 1'b0 || q !== 16'h0000)
            $display("FAIL countdown_after: got done=%b q=%h want 0 0000", done, q);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_q;
`ifdef BCD_DOWN_SATURATE_EN
        exp_q = 16'h0000;
`else
        exp_q = 16'h9999;
`endif
        set_in(1'b1, 1'b0, 1'b1, '0);
        #1;
        n_checks++;
        if (b_o !== 1'b1) $display("FAIL wrap_bo: got %b want 1", b_o);
        else n_pass++;
        tick();
        n_checks++;
        if (q !== exp_q) $display("FAIL wrap_q: got %h want %h", q, exp_q);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL wrap_done: got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_clamp();
        set_in(1'b1, 1'b1, 1'b1, 16'h3A0F);
        tick();
        n_checks++;
        if (q !== 16'h3909) $display("FAIL clamp_q: got %h want 3909", q);
        else n_pass++;
        n_checks++;
        if (ld_err !== 1'b1) $display("FAIL clamp_err: got %b want 1", ld_err);
        else n_pass++;
        set_in(1'b1, 1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if (ld_err !== 1'b0 || q !== 16'h3909)
            $display("FAIL clamp_after: got ld_err=%b q=%h want 0 3909", ld_err, q);
        else n_pass++;
    endtask

    task automatic test_clear_mid();
        set_in(1'b1, 1'b1, 1'b0, 16'h0500);
        tick();
        set_in(1'b0, 1'b0, 1'b1, '0);
        tick();
        n_checks++;
        if (q !== 16'h0000) $display("FAIL clrmid_q: got %h want 0000", q);
        else n_pass++;
        set_in(1'b1, 1'b1, 1'b1, 16'h0042);
        tick();
        n_checks++;
        if (q !== 16'h0042 || done !== 1'b0)
            $display("FAIL load_ena_q: got q=%h done=%b want 0042 0", q, done);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic         c, l, e;
            logic [W-1:0] d;
            c = ($urandom_range(0, 99) >= 3);
            l = ($urandom_range(0, 99) < 10);
            e = ($urandom_range(0, 99) < 75);
            d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : to_bcd(int'($urandom_range(0, 6)));
            set_in(c, l, e, d);
            #1;
            n_checks++;
            if (b_o !== (e && m_val == 0))
                $display("FAIL rand_bo[%0d]: got %b want %b", i, b_o, (e && m_val == 0));
            else n_pass++;
            tick();
            n_checks++;
            if (q !== to_bcd(m_val) || zero !== (m_val == 0) || done !== m_done || ld_err !== m_err)
                $display("FAIL rand_state[%0d]: got q=%h z=%b d=%b e=%b want q=%h z=%b d=%b e=%b",
                         i, q, zero, done, ld_err, to_bcd(m_val), (m_val == 0), m_done, m_err);
            else n_pass++;
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, '0);
        test_reset();
        test_ripple();
        test_countdown();
        test_wrap();
        test_clamp();
        test_clear_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Sequential, cascadable multi-digit BCD down-counter; the decrementing counterpart of the BCD up-count next-state logic.
- Holds DIGITS BCD digits in registers. Supports parallel load, enable-gated decrement with borrow ripple between digits, a combinational borrow-out for cascading, and a registered terminal-count pulse.
- Used for countdown timers and for lab 7-segment display drivers.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); total count width is 4*DIGITS.

Ports:
- clk      input   1          rising-edge clock; only clock in the block
- clr_n    input   1          synchronous active-low clear; sampled on rising clk edge
- ena      input   1          decrement enable (one count per clk while high)
- load     input   1          parallel load strobe
- din      input   4*DIGITS   load value; digit k at din[4k+3:4k]
- q        output  4*DIGITS   current count, registered; digit 0 is least significant
- b_o      output  1          borrow out, combinational: ena & (q == all zeros)
- zero     output  1          combinational: q == all zeros
- done     output  1          registered one-cycle pulse on reaching zero by decrement
- ld_err   output  1          registered one-cycle pulse: a loaded digit was > 9

Behaviour:
- Reset: on a clk edge with clr_n=0, q=0, done=0, ld_err=0. Clear overrides load and ena. Clear asserted mid-count takes effect on that edge and nothing else is updated. After reset, zero=1 and b_o=ena.
- Priority per edge: clr_n=0, then load=1, then ena=1, otherwise hold.
- Load:
  - q takes din with each digit > 9 (A..F) replaced by 9.
  - ld_err=1 on the next cycle if any digit was clamped, else 0.
  - ena is ignored on a load cycle.
  - done=0 on a load cycle, including a load of zero.
- Decrement (ena=1, load=0):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from digit k+1. Borrow into digit k = ena AND all lower digits == 0.
  - Pure BCD: digits never leave 0..9 once loaded through this block.
  - Latency is 1 clk from the ena edge to the q update.
- Wrap-around at all-zero with ena=1 (default build): q becomes all 9s (9999 for DIGITS=4). b_o is high during that cycle. done is not re-asserted.
- done is 1 for exactly one cycle after an edge that decremented q from 0..01 to 0..00. In every other cycle it is 0.
- b_o and zero are combinational from the q registers and ena, with no registered delay. This allows chaining: feed the lower counter's b_o into the upper counter's ena.
- ena held low leaves q unchanged. A load with ena=1 has no effect beyond the load.

Optional Feature:
- Macro: BCD_DOWN_SATURATE_EN.
- Defined: at all-zero with ena=1, q holds at zero instead of wrapping. b_o still follows ena & zero, so upstream cascades still see the borrow.
- Undefined: wrap to all 9s as described under Behaviour.
- done timing is the same in both builds.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - function bcd_clamp(digit) returning min(digit, 9)
- Sub-module bcd_digit_down_combin: one-digit combinational cell.
  - Inputs: d[3:0], bin (borrow in).
  - Outputs: next_d[3:0], bout = bin & (d==0).
  - Generated DIGITS times, with borrows chained.
  - Verified on its own with a vector-file bench covering all 16 d values × bin.

Test Plan (DIGITS=4):
- clr_n=0 for 1 clk with load=1, din=16'h1234, ena=1 -> q=16'h0000, zero=1, done=0, ld_err=0.
- load din=16'h1000, then ena=1 for 1 clk -> q=16'h0999. Borrow ripples through three digits in one cycle.
- load din=16'h0003, ena=1 for 3 clks -> q steps 0002, 0001, 0000. done=1 only in the cycle after the 0001->0000 edge. zero=1 afterwards.
- q=0000, ena=1 for 1 clk -> b_o=1 before the edge. Default build: q=9999 after the edge. With BCD_DOWN_SATURATE_EN: q=0000 after the edge. done=0 in both builds.
- load din=16'h3A0F -> q=16'h3909, ld_err=1 for one cycle, then 0.
- Mid-count at q=0500, ena=1 and clr_n=0 on the same edge -> q=0000. On a later edge with load=1, ena=1, din=0042 -> q=0042, no decrement applied.
